vdp_port: RTL

CPU-side I/O front end of the MSX video subsystem, TMS9918-compatible. Decodes Z80 accesses to the data port (0x98) and control port (0x99), keeps the 14-bit auto-incrementing VRAM pointer and the read-ahead buffer, and holds VDP registers R0–R7. Drives the CPU port of the dual-port VRAM. Supplies `mode`, `name_table_addr`, `font_addr` and `n_int` to the video renderer, and takes the frame-interrupt pulse back from it.

---
 rtl/vdp_pkg.sv | 36 +++
 rtl/vdp_regs.sv | 55 +++++
 rtl/vdp_port.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// vdp_port shared definitions: register indices, mode codes,
// prefetch FSM states and control-byte opcode masks.
package vdp_pkg;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_G1   = 2'd1;
  localparam logic [1:0] MODE_G2   = 2'd2;
  localparam logic [1:0] MODE_MC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_CAP
  } st_t;

  localparam logic [7:0] CTRL_REG      = 8'h80;
  localparam logic [7:0] CTRL_OP_MASK  = 8'hC0;
  localparam logic [7:0] CTRL_OP_WADDR = 8'h40;
  localparam logic [7:0] CTRL_OP_RADDR = 8'h00;

  typedef struct packed {
    logic       wr;
    logic       port;
    logic [7:0] data;
  } op_t;

endpackage

// File: rtl/vdp_regs.sv
// VDP register file R0-R7, frame flag F, mode decode
// and the renderer-facing base addresses and flags.
module vdp_regs
  import vdp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  idx,
  input  logic [7:0]  wdata,
  input  logic        frame_pulse,
  input  logic        f_clr,
  output logic        f,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] font_addr,
  output logic [7:0]  text_colour,
  output logic        blank,
  output logic        n_int
);

  logic [7:0] r [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r[i] <= 8'h00;
    end else if (we) begin
      r[idx] <= wdata;
    end
  end

  // a frame pulse beats a simultaneous status read
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            f <= 1'b0;
    else if (frame_pulse) f <= 1'b1;
    else if (f_clr)       f <= 1'b0;
  end

  always_comb begin
    mode = MODE_G1;
    priority case (1'b1)
      r[R1][4]: mode = MODE_TEXT;
      r[R0][1]: mode = MODE_G2;
      r[R1][3]: mode = MODE_MC;
      default:  mode = MODE_G1;
    endcase
  end

  assign name_table_addr = {r[R2][3:0], 10'b0};
  assign font_addr       = {r[R4][2:0], 11'b0};
  assign text_colour     = r[R7];
  assign blank           = ~r[R1][6];
  assign n_int           = ~(f & r[R1][5]);

endmodule

// File: rtl/vdp_port.sv
// TMS9918-style CPU port: latch, VRAM pointer, prefetch FSM, pending slot.
// Define VDP_DIAG_EN to add the diag output.
module vdp_port
  import vdp_pkg::*;
#(
  parameter int VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               port_sel,
  input  logic               cpu_wr,
  input  logic               cpu_rd,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  input  logic [7:0]         vram_rdata,
  input  logic               frame_pulse,
  output logic [1:0]         mode,
  output logic [13:0]        name_table_addr,
  output logic [13:0]        font_addr,
  output logic [7:0]         text_colour,
  output logic               blank,
  output logic               n_int
`ifdef VDP_DIAG_EN
  ,
  output logic [7:0]         diag
`endif
);

  st_t state, state_d;

  logic [VRAM_AW-1:0] ptr;
  logic [7:0]         latch;
  logic [7:0]         rbuf;
  logic               second_byte;
  logic               f;

  op_t  new_op, pend, pend_d, ex;
  logic new_v, pend_v, pend_v_d, ex_v;

  assign new_v  = cpu_wr | cpu_rd;
  assign new_op = '{wr: cpu_wr, port: port_sel, data: cpu_din};

  // while busy, one strobe is parked; the slot drains on return to IDLE
  always_comb begin
    ex_v     = 1'b0;
    ex       = new_op;
    pend_v_d = pend_v;
    pend_d   = pend;
    if (state == ST_IDLE) begin
      if (pend_v) begin
        ex_v     = 1'b1;
        ex       = pend;
        pend_v_d = new_v;
        pend_d   = new_op;
      end else begin
        ex_v = new_v;
      end
    end else if (new_v && !pend_v) begin
      pend_v_d = 1'b1;
      pend_d   = new_op;
    end
  end

  logic d_wr, d_rd, c_wr, c_rd;
  logic c_first, c_second;
  logic reg_we, set_waddr, set_raddr, start_pf;

  assign d_wr      = ex_v & ex.wr & ~ex.port;
  assign d_rd      = ex_v & ~ex.wr & ~ex.port;
  assign c_wr      = ex_v & ex.wr & ex.port;
  assign c_rd      = ex_v & ~ex.wr & ex.port;
  assign c_first   = c_wr & ~second_byte;
  assign c_second  = c_wr & second_byte;
  assign reg_we    = c_second & |(ex.data & CTRL_REG);
  assign set_waddr = c_second &
                     ((ex.data & CTRL_OP_MASK) == CTRL_OP_WADDR);
  assign set_raddr = c_second &
                     ((ex.data & CTRL_OP_MASK) == CTRL_OP_RADDR);
  assign start_pf  = d_rd | set_raddr;

  logic [VRAM_AW-1:0] new_ptr;
  assign new_ptr = {ex.data[5:0], latch};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:    if (start_pf) state_d = ST_RD_ADDR;
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v      <= 1'b0;
      pend        <= '0;
      ptr         <= '0;
      latch       <= 8'h00;
      rbuf        <= 8'h00;
      second_byte <= 1'b0;
      cpu_dout    <= 8'h00;
      vram_addr   <= '0;
      vram_wdata  <= 8'h00;
      vram_we     <= 1'b0;
    end else begin
      pend_v  <= pend_v_d;
      pend    <= pend_d;
      vram_we <= 1'b0;
      if (c_first) begin
        latch       <= ex.data;
        second_byte <= 1'b1;
      end else if (ex_v) begin
        second_byte <= 1'b0;
      end
      unique case (1'b1)
        d_wr: begin
          vram_we    <= 1'b1;
          vram_addr  <= ptr;
          vram_wdata <= ex.data;
          rbuf       <= ex.data;
          ptr        <= ptr + VRAM_AW'(1);
        end
        d_rd: begin
          cpu_dout  <= rbuf;
          vram_addr <= ptr;
        end
        c_rd: cpu_dout <= {f, 7'b0};
        set_waddr: ptr <= new_ptr;
        set_raddr: begin
          ptr       <= new_ptr;
          vram_addr <= new_ptr;
        end
        (state == ST_RD_CAP): begin
          rbuf <= vram_rdata;
          ptr  <= ptr + VRAM_AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef VDP_DIAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       diag <= 8'h00;
    else if (reg_we) diag <= latch;
    else if (d_wr)   diag <= ptr[7:0];
  end
`endif

  vdp_regs u_regs (
    .clk             (clk),
    .reset           (reset),
    .we              (reg_we),
    .idx             (ex.data[2:0]),
    .wdata           (latch),
    .frame_pulse     (frame_pulse),
    .f_clr           (c_rd),
    .f               (f),
    .mode            (mode),
    .name_table_addr (name_table_addr),
    .font_addr       (font_addr),
    .text_colour     (text_colour),
    .blank           (blank),
    .n_int           (n_int)
  );

endmodule
